writeback_buffer: RTL and testbench
===================================

# writeback_buffer

Write-back buffer between the two-way set-associative cache/controller and main memory. Holds dirty 64-bit victim lines evicted by the cache, drains them to memory in the background, and services cache line-fill reads. A fill read that matches a buffered line is answered from the buffer; a miss goes to memory ahead of pending drains. Lets the controller finish a victim eviction in one cycle instead of waiting on a memory write.

## Interface
- DEPTH, 4, buffered lines (power of two, ≥2)
- ADDR_W, 14, line address width (16-bit word address minus 2-bit word offset)
- LINE_W, 64, line width (four 16-bit words)

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_valid  in  1  victim line offered by cache
- wb_addr  in  ADDR_W  victim line address
- wb_data  in  LINE_W  victim line data
- wb_ready  out  1  buffer can accept; transfer when wb_valid && wb_ready
- rd_req  in  1  fill-read request, held high until rd_done
- rd_addr  in  ADDR_W  fill line address, stable while rd_req high
- rd_data  out  LINE_W  fill data, valid when rd_done high
- rd_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory transaction active
- mem_rd_wrt  out  1  1 = read, 0 = write
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_rdy
- mem_rdy  in  1  memory completes current transaction this cycle
- empty  out  1  no valid entries
- full  out  1  DEPTH valid entries

## Operation
- Storage: circular FIFO of DEPTH entries {valid, addr, data}, with head and tail pointers and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- wb_ready = !full, registered from count. It is not raised in a cycle where a drain completes.
- Enqueue coalescing: if wb_addr matches a valid entry that is not the head currently being drained, that entry's data is overwritten and count is unchanged. Otherwise the line is written at tail, tail advances, and count increments.
- Read lookup: compares rd_addr against all valid entries and against an accepted same-cycle enqueue. The same-cycle enqueue wins, then the youngest entry. A match returns buffered data and generates no memory access.
- FSM states: IDLE, HIT, MEM_RD, MEM_WR.
  - IDLE, rd_req and lookup hit: capture data, go to HIT.
  - IDLE, rd_req and lookup miss: go to MEM_RD. Reads take priority over drains.
  - IDLE, no rd_req and !empty: go to MEM_WR with the head entry.
  - HIT: pulse rd_done, return to IDLE.
  - MEM_RD: on mem_rdy, register mem_rdata into rd_data, pulse rd_done next cycle, return to IDLE.
  - MEM_WR: on mem_rdy, pop head (clear valid, advance head, decrement count), return to IDLE.
- mem_en, mem_rd_wrt, mem_addr and mem_wdata are registered and held stable for the whole MEM_RD/MEM_WR transaction. mem_en drops the cycle after mem_rdy.
- Enqueue and drain pop in the same cycle: count is unchanged and both pointers advance.
- A read that hits the head being drained still hits; the data stays valid until the pop.
- Simultaneous push and pop when full: the push is impossible because wb_ready is low.

## Timing
- Reset values: wb_ready=1, empty=1, full=0, mem_en=0, mem_rd_wrt=1, mem_addr=0, mem_wdata=0, rd_data=0, rd_done=0. State = IDLE, all valid bits = 0, pointers = 0.
- rst asserted mid-transaction abandons it. mem_en is 0 in the cycle after rst is sampled, and buffered lines are discarded.
- Hit latency: rd_req sampled in IDLE → rd_done 2 cycles later.
- Miss latency: mem_en high 1 cycle after rd_req is sampled → rd_done 1 cycle after mem_rdy.
- Drain: mem_en high 1 cycle after IDLE is entered with !empty and no rd_req.
- rd_req sampled only in IDLE. A request arriving during MEM_WR waits for that drain to finish.
- empty and full are registered and update the cycle after the enqueue or pop.

## Structure
- Shared package mem_sys_pkg: ADDR_W, LINE_W, state enum {IDLE, HIT, MEM_RD, MEM_WR}, and the mem_rd_wrt encoding constants.
- One sub-module, wbb_store: entry array, pointers, count, coalesce match, and youngest-match read lookup.
- The FSM and memory port registers live in the top level.

## Test plan
- Reset, then check every output equals its reset value. Assert rst during MEM_WR → mem_en=0 next cycle, empty=1.
- Enqueue 0x0000/0x0000_0000_0000_2000 with rd_req low → MEM_WR with mem_addr=0x0000. With mem_rdy after 3 cycles → empty=1 one cycle later.
- Hold mem_rdy low and enqueue 4 distinct addresses → full=1, wb_ready=0. A fifth wb_valid is not accepted. Release mem_rdy → one pop, wb_ready=1.
- Enqueue 0x3FF8 twice with data 0x0F00 then 0x0F01 → count=1, and the drain writes 0x..0F01.
- Enqueue 0x3FF8, then rd_req on 0x3FF8 → rd_done 2 cycles later with buffered data, and no mem_rd_wrt=1 transaction.
- Buffer holds 0x0001, rd_req on 0x2FF8 → memory read issued before the drain, rd_data=mem_rdata. Drain of 0x0001 follows.

Source files
------------

// File: rtl/mem_sys_pkg.sv
// Shared memory-system definitions: line geometry, write-back buffer FSM states
// and the mem_rd_wrt encoding.
package mem_sys_pkg;

    localparam int ADDR_W = 14;
    localparam int LINE_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIT    = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } wbb_state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/wbb_store.sv
// Victim-line storage for the write-back buffer: circular FIFO with coalescing
// on enqueue and a youngest-match lookup for fill reads.
module wbb_store #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = mem_sys_pkg::ADDR_W,
    parameter int LINE_W = mem_sys_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    input  logic              pop,
    input  logic              head_lock,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [LINE_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              empty_q;
    logic              full_q;

    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic              push_new;
    logic [PTR_W-1:0]  age_idx;

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign empty     = empty_q;
    assign full      = full_q;

    // The head entry is off limits for coalescing once its drain has been
    // committed, since mem_wdata already holds a copy of it.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == push_addr) &&
                !(head_lock && (PTR_W'(i) == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign push_new = push && !coal_hit;
    assign count_d  = count_q + CNT_W'(push_new) - CNT_W'(pop);

    // Walk oldest to youngest so the last match wins; a same-cycle enqueue
    // is newer than anything stored.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        age_idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            age_idx = head_q + PTR_W'(i);
            if (valid_q[age_idx] && (addr_q[age_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[age_idx];
            end
        end
        if (push && (push_addr == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push) begin
                if (coal_hit) begin
                    data_q[coal_idx] <= push_data;
                end else begin
                    valid_q[tail_q] <= 1'b1;
                    addr_q[tail_q]  <= push_addr;
                    data_q[tail_q]  <= push_data;
                    tail_q          <= tail_q + PTR_W'(1);
                end
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer top: accepts dirty victim lines, drains them to memory in
// the background and answers fill reads from the buffer or from memory.
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = mem_sys_pkg::ADDR_W,
    parameter int LINE_W = mem_sys_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_done,
    output logic              mem_en,
    output logic              mem_rd_wrt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              empty,
    output logic              full
);

    import mem_sys_pkg::*;

    // Handshakes: a victim transfers on a clock edge where wb_valid && wb_ready;
    // rd_req is held until the one-cycle rd_done pulse; a memory transaction
    // holds mem_en and its fields stable until the edge where mem_rdy is high.

    wbb_state_t        state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rd_wrt_q, mem_rd_wrt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_done_q, rd_done_d;

    logic              push;
    logic              pop;
    logic              rd_go;
    logic              head_lock;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic [ADDR_W-1:0] head_addr;
    logic [LINE_W-1:0] head_data;
    logic              st_empty;
    logic              st_full;

    assign wb_ready = !st_full;
    assign push     = wb_valid && wb_ready;
    // The requester still holds rd_req during the rd_done cycle; ignore it then.
    assign rd_go    = rd_req && !rd_done_q;
    assign pop      = (state_q == MEM_WR) && mem_rdy;
    assign head_lock = (state_q == MEM_WR) ||
                       ((state_q == IDLE) && !rd_go && !st_empty);

    wbb_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (wb_addr),
        .push_data   (wb_data),
        .pop         (pop),
        .head_lock   (head_lock),
        .lookup_addr (rd_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .empty       (st_empty),
        .full        (st_full)
    );

    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_rd_wrt_d = mem_rd_wrt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_data_d    = rd_data_q;
        rd_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_go) begin
                    if (lookup_hit) begin
                        rd_data_d = lookup_data;
                        state_d   = HIT;
                    end else begin
                        mem_en_d     = 1'b1;
                        mem_rd_wrt_d = MEM_READ;
                        mem_addr_d   = rd_addr;
                        state_d      = MEM_RD;
                    end
                end else if (!st_empty) begin
                    mem_en_d     = 1'b1;
                    mem_rd_wrt_d = MEM_WRITE;
                    mem_addr_d   = head_addr;
                    mem_wdata_d  = head_data;
                    state_d      = MEM_WR;
                end
            end
            HIT: begin
                rd_done_d = 1'b1;
                state_d   = IDLE;
            end
            MEM_RD: begin
                if (mem_rdy) begin
                    rd_data_d = mem_rdata;
                    rd_done_d = 1'b1;
                    mem_en_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_rdy) begin
                    mem_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_rd_wrt_q <= MEM_READ;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_rd_wrt_q <= mem_rd_wrt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_done_q    <= rd_done_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_rd_wrt = mem_rd_wrt_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_data    = rd_data_q;
    assign rd_done    = rd_done_q;
    assign empty      = st_empty;
    assign full       = st_full;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: reset values, drains, full/back-pressure,
// coalescing, buffered read hit and memory read miss.
module tb_writeback_buffer;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [13:0] wb_addr;
    logic [63:0] wb_data;
    logic        wb_ready;
    logic        rd_req;
    logic [13:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_done;
    logic        mem_en;
    logic        mem_rd_wrt;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;
    int rd_cycles = 0;
    logic [77:0] exp_q[$];

    writeback_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .mem_en     (mem_en),
        .mem_rd_wrt (mem_rd_wrt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rdy    (mem_rdy),
        .empty      (empty),
        .full       (full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // memory read cycles seen on the port
    always @(negedge clk) begin
        if (!rst && mem_en === 1'b1 && mem_rd_wrt === 1'b1) rd_cycles++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [13:0] a, input logic [63:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain_next();
        logic [77:0] e;
        int n;
        e = exp_q.pop_front();
        n = 0;
        while (mem_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_start", 64'(mem_en), 64'd1);
        chk("drain_wrt", 64'(mem_rd_wrt), 64'd0);
        chk("drain_addr", 64'(mem_addr), 64'(e[77:64]));
        chk("drain_data", mem_wdata, e[63:0]);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_req = 1'b0; rd_addr = '0; mem_rdata = '0; mem_rdy = 1'b0;
        tick(2);
        rst = 1'b0;

        // reset values
        chk("rst_wb_ready", 64'(wb_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_rd_wrt", 64'(mem_rd_wrt), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_done", 64'(rd_done), 64'd0);

        // single drain with mem_rdy after 3 cycles
        push_line(14'h0000, 64'h0000_0000_0000_2000);
        chk("d1_empty", 64'(empty), 64'd0);
        tick();
        chk("d1_mem_en", 64'(mem_en), 64'd1);
        chk("d1_wrt", 64'(mem_rd_wrt), 64'd0);
        chk("d1_addr", 64'(mem_addr), 64'h0000);
        chk("d1_wdata", mem_wdata, 64'h0000_0000_0000_2000);
        tick(2);
        chk("d1_hold_en", 64'(mem_en), 64'd1);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("d1_empty_after", 64'(empty), 64'd1);
        chk("d1_en_drop", 64'(mem_en), 64'd0);

        // reset during MEM_WR abandons the drain and discards lines
        push_line(14'h0010, 64'h55);
        tick();
        chk("rw_mem_en", 64'(mem_en), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_en_off", 64'(mem_en), 64'd0);
        chk("rw_empty", 64'(empty), 64'd1);
        tick(2);
        chk("rw_no_drain", 64'(mem_en), 64'd0);

        // fill to full while memory stalls
        for (int i = 0; i < 4; i++) begin
            push_line(14'h0100 + 14'(i), 64'hD000 + 64'(i));
            exp_q.push_back({14'h0100 + 14'(i), 64'hD000 + 64'(i)});
        end
        chk("full_full", 64'(full), 64'd1);
        chk("full_ready", 64'(wb_ready), 64'd0);
        push_line(14'h0200, 64'hDEAD);
        chk("full_still", 64'(full), 64'd1);
        drain_next();
        chk("full_pop_ready", 64'(wb_ready), 64'd1);
        chk("full_pop_full", 64'(full), 64'd0);
        for (int i = 0; i < 3; i++) drain_next();
        chk("full_empty", 64'(empty), 64'd1);
        tick(2);
        chk("full_no_fifth", 64'(mem_en), 64'd0);

        // coalescing behind a stalled drain
        push_line(14'h0200, 64'hAAAA);
        exp_q.push_back({14'h0200, 64'hAAAA});
        push_line(14'h3FF8, 64'h0F00);
        push_line(14'h3FF8, 64'h0F01);
        exp_q.push_back({14'h3FF8, 64'h0F01});
        drain_next();
        drain_next();
        chk("coal_empty", 64'(empty), 64'd1);
        tick(2);
        chk("coal_no_extra", 64'(mem_en), 64'd0);

        // read hit served from the buffer
        push_line(14'h3FF8, 64'h1234);
        exp_q.push_back({14'h3FF8, 64'h1234});
        rd_req = 1'b1;
        rd_addr = 14'h3FF8;
        tick();
        chk("hit_not_yet", 64'(rd_done), 64'd0);
        tick();
        chk("hit_done", 64'(rd_done), 64'd1);
        chk("hit_data", rd_data, 64'h1234);
        rd_req = 1'b0;
        tick();
        chk("hit_pulse", 64'(rd_done), 64'd0);
        drain_next();
        chk("hit_no_memrd", 64'(rd_cycles), 64'd0);

        // read miss goes to memory ahead of the pending drain
        push_line(14'h0001, 64'hBEEF);
        exp_q.push_back({14'h0001, 64'hBEEF});
        rd_req = 1'b1;
        rd_addr = 14'h2FF8;
        tick();
        chk("miss_en", 64'(mem_en), 64'd1);
        chk("miss_rd", 64'(mem_rd_wrt), 64'd1);
        chk("miss_addr", 64'(mem_addr), 64'h2FF8);
        mem_rdata = 64'hCAFE_F00D_1234_5678;
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("miss_done", 64'(rd_done), 64'd1);
        chk("miss_data", rd_data, 64'hCAFE_F00D_1234_5678);
        chk("miss_en_drop", 64'(mem_en), 64'd0);
        rd_req = 1'b0;
        drain_next();
        chk("miss_empty", 64'(empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
